// File: rtl/cpu_control.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_control
//  Purpose  : Control unit for a simple multi-cycle processor. Captures a
//             9-bit instruction III_XXX_YYY from din when run is seen in T0,
//             then sequences bus-source selects and register load strobes
//             for mv, mvi, add and sub across states T0..T3.
//  Ports    : clk     - system clock, rising edge
//             resetn  - asynchronous active-low reset
//             run     - start request, sampled in T0 only
//             din     - external data, din[8:0] = instruction word
//             select  - one-hot bus source {R7..R0, G, din}
//             r_in    - register file write enables, bit n = Rn
//             ir_in   - instruction register load strobe
//             a_in    - ALU A-operand register load
//             g_in    - ALU result register G load
//             addsub  - ALU operation, 0 = add, 1 = subtract
//             done    - last cycle of the current instruction
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_control #(
  parameter int word = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            run,
  input  logic [word-1:0] din,
  output logic [9:0]      select,
  output logic [7:0]      r_in,
  output logic            ir_in,
  output logic            a_in,
  output logic            g_in,
  output logic            addsub,
  output logic            done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_t     state_q, state_d;
  logic [8:0] ir_q, ir_d;
  logic [2:0] opcode, rx, ry;

  assign opcode = ir_q[8:6];
  assign rx     = ir_q[5:3];
  assign ry     = ir_q[2:0];

  // Only the instruction field of din is used by the control unit.
  if (word > 9) begin : g_din_unused
    logic unused_din_hi;
    assign unused_din_hi = ^din[word-1:9];
  end

  // Register Rn sits at select bit n+2 (bit0 = din, bit1 = G).
  function automatic logic [9:0] sel_reg(input logic [2:0] n);
    return 10'd4 << n;
  endfunction

  function automatic logic [7:0] wr_reg(input logic [2:0] n);
    return 8'd1 << n;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    select  = '0;
    r_in    = '0;
    ir_in   = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    addsub  = 1'b0;
    done    = 1'b0;

    case (state_q)
      T0: begin
        // Reset forces T0 asynchronously; gating with resetn keeps the
        // load strobe low while reset is held even if run is high.
        ir_in = run & resetn;
        if (run) begin
          ir_d    = din[8:0];
          state_d = T1;
        end
      end

      T1: begin
        case (opcode)
          OP_MV: begin
            select  = sel_reg(ry);
            r_in    = wr_reg(rx);
            done    = 1'b1;
            state_d = T0;
          end
          OP_MVI: begin
            select  = 10'd1;
            r_in    = wr_reg(rx);
            done    = 1'b1;
            state_d = T0;
          end
          OP_ADD, OP_SUB: begin
            select  = sel_reg(rx);
            a_in    = 1'b1;
            state_d = T2;
          end
          default: begin
            // Undefined opcodes retire immediately with no side effects.
            done    = 1'b1;
            state_d = T0;
          end
        endcase
      end

      T2: begin
        select  = sel_reg(ry);
        g_in    = 1'b1;
        addsub  = (opcode == OP_SUB);
        state_d = T3;
      end

      T3: begin
        select  = 10'd2;
        r_in    = wr_reg(rx);
        done    = 1'b1;
        state_d = T0;
      end

      default: begin
        state_d = T0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_control
//  Purpose  : Self-checking bench for cpu_control. Each scenario task queues
//             per-cycle expected output vectors together with the din/run
//             stimulus, then replays the stimulus and compares the DUT
//             outputs against the popped expectation on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_control;

  localparam int WORD = 16;

  logic            clk = 1'b0;
  logic            resetn;
  logic            run;
  logic [WORD-1:0] din;
  logic [9:0]      select;
  logic [7:0]      r_in;
  logic            ir_in;
  logic            a_in;
  logic            g_in;
  logic            addsub;
  logic            done;

  cpu_control #(.word(WORD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .run    (run),
    .din    (din),
    .select (select),
    .r_in   (r_in),
    .ir_in  (ir_in),
    .a_in   (a_in),
    .g_in   (g_in),
    .addsub (addsub),
    .done   (done)
  );

  always #5 clk = ~clk;

  // {select[9:0], r_in[7:0], ir_in, a_in, g_in, addsub, done}
  typedef logic [22:0] vec_t;

  vec_t            exp_q[$];
  logic [WORD-1:0] din_q[$];
  logic            run_q[$];

  int   checks  = 0;
  int   fails   = 0;
  int   cyc     = 0;
  logic watch_r7 = 1'b0;
  logic r7_seen  = 1'b0;

  vec_t outs;
  assign outs = {select, r_in, ir_in, a_in, g_in, addsub, done};

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    checks++;
    if (!$onehot0(select)) begin
      fails++;
      $display("FAIL select_onehot cycle %0d: select=%b, required at most one bit set", cyc, select);
    end
    if (watch_r7 && r_in[7]) r7_seen = 1'b1;
  end

  function automatic vec_t mk(input logic [9:0] sel, input logic [7:0] rin,
                              input logic ir, input logic a, input logic g,
                              input logic as, input logic d);
    return {sel, rin, ir, a, g, as, d};
  endfunction

  function automatic logic [WORD-1:0] rnd();
    return WORD'($urandom);
  endfunction

  function automatic void sched(input vec_t e, input logic [WORD-1:0] d, input logic r);
    exp_q.push_back(e);
    din_q.push_back(d);
    run_q.push_back(r);
  endfunction

  // Reference model of the instruction sequencing, used for generated traffic.
  function automatic void model_instr(input logic [8:0] ins, input logic run_exec);
    logic [2:0]      op, x, y;
    logic [9:0]      sx, sy;
    logic [7:0]      wx;
    logic [WORD-1:0] d;
    op = ins[8:6];
    x  = ins[5:3];
    y  = ins[2:0];
    sx = '0; sx[{1'b0, x} + 4'd2] = 1'b1;
    sy = '0; sy[{1'b0, y} + 4'd2] = 1'b1;
    wx = '0; wx[x] = 1'b1;
    d = rnd();
    d[8:0] = ins;
    sched(mk(10'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), d, 1'b1);
    case (op)
      3'b000: sched(mk(sy, wx, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), rnd(), run_exec);
      3'b001: sched(mk(10'd1, wx, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), rnd(), run_exec);
      3'b010, 3'b011: begin
        sched(mk(sx, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), rnd(), run_exec);
        sched(mk(sy, 8'd0, 1'b0, 1'b0, 1'b1, op[0], 1'b0), rnd(), run_exec);
        sched(mk(10'd2, wx, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), rnd(), run_exec);
      end
      default: sched(mk(10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), rnd(), run_exec);
    endcase
  endfunction

  task automatic test_reset();
    vec_t e;
    resetn = 1'b0;
    run    = 1'b1;
    din    = 16'h0040;
    #3;
    checks++;
    if (outs !== '0) begin
      fails++;
      $display("FAIL reset_async: got %b, expected all zero", outs);
    end
    @(posedge clk); #1;
    checks++;
    if (outs !== '0) begin
      fails++;
      $display("FAIL reset_held_run_high: got %b, expected all zero", outs);
    end
    run    = 1'b0;
    resetn = 1'b1;
    repeat (5) sched('0, rnd(), 1'b0);
    while (exp_q.size() > 0) begin
      run = run_q.pop_front();
      din = din_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: got %b, expected %b", cyc, outs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mvi();
    vec_t e;
    sched(mk(10'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 16'h0040, 1'b1);
    sched(mk(10'b00_0000_0001, 8'b0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 16'hABCD, 1'b0);
    sched('0, rnd(), 1'b0);
    while (exp_q.size() > 0) begin
      run = run_q.pop_front();
      din = din_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        fails++;
        $display("FAIL mvi_r0 cycle %0d: got %b, expected %b", cyc, outs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mv();
    vec_t e;
    sched(mk(10'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 16'h0018, 1'b1);
    sched(mk(10'b00_0000_0100, 8'b0000_1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), rnd(), 1'b0);
    sched('0, rnd(), 1'b0);
    while (exp_q.size() > 0) begin
      run = run_q.pop_front();
      din = din_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        fails++;
        $display("FAIL mv_r3_r0 cycle %0d: got %b, expected %b", cyc, outs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add();
    vec_t e;
    sched(mk(10'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 16'h008A, 1'b1);
    sched(mk(10'b00_0000_1000, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), rnd(), 1'b0);
    sched(mk(10'b00_0001_0000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), rnd(), 1'b0);
    sched(mk(10'b00_0000_0010, 8'b0000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), rnd(), 1'b0);
    sched('0, rnd(), 1'b0);
    while (exp_q.size() > 0) begin
      run = run_q.pop_front();
      din = din_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        fails++;
        $display("FAIL add_r1_r2 cycle %0d: got %b, expected %b", cyc, outs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_undefined();
    vec_t e;
    sched(mk(10'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 16'h01C0, 1'b1);
    sched(mk(10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), rnd(), 1'b0);
    sched('0, rnd(), 1'b0);
    while (exp_q.size() > 0) begin
      run = run_q.pop_front();
      din = din_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        fails++;
        $display("FAIL undefined_op cycle %0d: got %b, expected %b", cyc, outs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_sub();
    vec_t e;
    watch_r7 = 1'b1;
    r7_seen  = 1'b0;
    // run stays high through T1/T2 and must be ignored there.
    sched(mk(10'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 16'h00FE, 1'b1);
    sched(mk(10'b10_0000_0000, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 16'h0040, 1'b1);
    sched(mk(10'b01_0000_0000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), 16'h0040, 1'b1);
    while (exp_q.size() > 0) begin
      run = run_q.pop_front();
      din = din_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        fails++;
        $display("FAIL sub_r7_r6 cycle %0d: got %b, expected %b", cyc, outs, e);
      end
      if (exp_q.size() > 0) begin
        @(posedge clk); #1;
      end
    end
    #1;
    resetn = 1'b0;
    run    = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin
      fails++;
      $display("FAIL reset_mid_async: got %b, expected all zero", outs);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (outs !== '0) begin
      fails++;
      $display("FAIL reset_mid_held: got %b, expected all zero", outs);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    sched(mk(10'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 16'h0018, 1'b1);
    sched(mk(10'b00_0000_0100, 8'b0000_1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), rnd(), 1'b0);
    sched('0, rnd(), 1'b0);
    while (exp_q.size() > 0) begin
      run = run_q.pop_front();
      din = din_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        fails++;
        $display("FAIL fresh_after_reset cycle %0d: got %b, expected %b", cyc, outs, e);
      end
      @(posedge clk); #1;
    end
    watch_r7 = 1'b0;
    checks++;
    if (r7_seen !== 1'b0) begin
      fails++;
      $display("FAIL aborted_sub_r7_write: got r_in[7] seen=%b, expected 0", r7_seen);
    end
  endtask

  task automatic test_back_to_back();
    vec_t       e;
    logic [8:0] prog[$];
    prog = '{9'b010_101_101, 9'b000_010_010, 9'b011_000_111, 9'b001_110_000, 9'b101_011_001};
    repeat (8) prog.push_back(9'($urandom_range(0, 511)));
    foreach (prog[i]) model_instr(prog[i], 1'b1);
    sched('0, rnd(), 1'b0);
    while (exp_q.size() > 0) begin
      run = run_q.pop_front();
      din = din_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        fails++;
        $display("FAIL back_to_back cycle %0d: got %b, expected %b", cyc, outs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    run    = 1'b0;
    din    = '0;
    test_reset();
    test_mvi();
    test_mv();
    test_add();
    test_undefined();
    test_reset_mid_sub();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_control.md
CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 Parameter: word, default 16, datapath width of din.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: resetn  input  1  asynchronous, active-low reset.
REQ-004 Port: run  input  1  start request, sampled only in state T0.
REQ-005 Port: din  input  word  external data; din[8:0] holds the instruction word III_XXX_YYY.
REQ-006 Port: select  output  10  one-hot bus-source select, bit order [R7,...,R0,G,din]; bit0=din, bit1=G, bit2=R0 ... bit9=R7.
REQ-007 Port: r_in  output  8  register-file write enables, bit n = Rn.
REQ-008 Port: ir_in  output  1  instruction register load strobe, for observation.
REQ-009 Port: a_in  output  1  ALU A-operand register load.
REQ-010 Port: g_in  output  1  ALU result register G load.
REQ-011 Port: addsub  output  1  ALU operation; 0 = add, 1 = subtract.
REQ-012 Port: done  output  1  last cycle of the current instruction.

Function
REQ-013 The block SHALL hold an internal 9-bit instruction register IR, loaded from din[8:0] on the clock edge at which ir_in=1.
REQ-014 The FSM SHALL have exactly four states: T0, T1, T2, T3.
REQ-015 T0: ir_in=run; if run=1, load IR and go to T1; else stay in T0 with IR unchanged.
REQ-016 run SHALL be ignored in T1..T3 (no preemption, no queuing).
REQ-017 Outputs SHALL depend only on state and IR, except ir_in (state T0 and run).
REQ-018 select SHALL be one-hot or all-zero in every cycle; two or more bits set is a design error.
REQ-019 Every output not explicitly asserted in a state SHALL be 0.
REQ-020 Opcode 000 (mv Rx,Ry) in T1: select=Ry, r_in[X]=1, done=1; next state T0.
REQ-021 Opcode 001 (mvi Rx,#D) in T1: select=din (bit0), r_in[X]=1, done=1; next state T0; the immediate value is on din during this cycle.
REQ-022 Opcode 010 (add) and 011 (sub), three execution cycles:
 - T1: select=Rx, a_in=1; go to T2.
 - T2: select=Ry, g_in=1, addsub=0 for add and 1 for sub; go to T3.
 - T3: select=G (bit1), r_in[X]=1, done=1; go to T0.
REQ-023 Opcodes 100..111 (undefined) in T1: done=1, select=0, r_in=0; next state T0.
REQ-024 X=Y is legal; mv Rx,Rx writes Rx back unchanged, and add Rx,Rx doubles Rx.
REQ-025 T2 and T3 SHALL be reached only for opcodes 010 and 011.
REQ-026 After done, the next cycle SHALL be T0; back-to-back instructions are accepted if run=1 there.

Reset
REQ-027 resetn=0 SHALL immediately (asynchronously) force state T0 and IR=0, and drive select, r_in, ir_in, a_in, g_in, addsub and done to 0.
REQ-028 Reset asserted mid-instruction SHALL abort it with no further r_in, g_in or a_in pulses.
REQ-029 After resetn rises, the first accepted instruction SHALL be the one presented with run=1 in T0.

Verification
REQ-030 Reset and idle: resetn=0 -> all outputs 0; release with run=0 for 5 cycles -> ir_in=0, state stays T0, all outputs 0.
REQ-031 mvi R0: din=9'b001_000_000, run=1 in T0 -> ir_in=1; next cycle select=10'b00_0000_0001, r_in=8'b0000_0001, done=1; following cycle all 0.
REQ-032 mv R3,R0: din=9'b000_011_000 -> in T1 select=10'b00_0000_0100, r_in=8'b0000_1000, done=1.
REQ-033 add R1,R2: din=9'b010_001_010 -> the following execution sequence:
 - T1: select=10'b00_0000_1000, a_in=1.
 - T2: select=10'b00_0001_0000, g_in=1, addsub=0.
 - T3: select=10'b00_0000_0010, r_in=8'b0000_0010, done=1.
REQ-034 sub R7,R6 with resetn pulsed low during T2: din=9'b011_111_110 -> T2 shows addsub=1; at the reset edge all outputs go to 0; r_in[7] never asserts; run=1 after release starts a fresh instruction.
REQ-035 Undefined opcode and one-hot check: din=9'b111_000_000 -> in T1 done=1, select=0, r_in=0, next state T0; across all scenarios, assert that select is never multi-hot.
